regfile_wb_arbiter: RTL and testbench

Write-port arbiter and pending-write scoreboard for the 32-entry register file. Up to `n_req` writeback sources (ALU, load unit, mul/div, CP0) compete for the single register-file write port. A registered round-robin grant drives `W_addr`/`W_data`/`wr_enable`, and a 32-bit busy scoreboard tracks destinations that are reserved at issue and not yet written back. The block sits between the execute/memory writeback sources and `regfile`; the decode stage reads `busy` for hazard stalls.

---
 rtl/regfile_wb_arbiter.sv | 100 ++++++++++
 tb/tb_regfile_wb_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single register-file write port, plus a busy
// scoreboard of destinations reserved at issue and still awaiting writeback.
module regfile_wb_arbiter #(
  parameter int width = 32,
  parameter int n_req = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [n_req-1:0]       wb_valid,
  input  logic [n_req*5-1:0]     wb_addr,
  input  logic [n_req*width-1:0] wb_data,
  output logic [n_req-1:0]       wb_ready,
  input  logic                   rsv_en,
  input  logic [4:0]             rsv_addr,
  output logic [4:0]             W_addr,
  output logic [width-1:0]       W_data,
  output logic                   wr_enable,
  output logic [31:0]            busy
);

  localparam int idx_w = (n_req > 1) ? $clog2(n_req) : 1;
  typedef logic [idx_w-1:0] idx_t;

  logic [4:0]       addr_arr [n_req];
  logic [width-1:0] data_arr [n_req];

  idx_t             last_reg;
  idx_t             grant_idx;
  logic             grant_found;
  logic             transfer;
  logic [4:0]       w_addr_reg;
  logic [width-1:0] w_data_reg;
  logic             wr_enable_reg;
  logic [31:0]      busy_reg;
  logic [31:0]      busy_next;

  genvar gi;
  generate
    for (gi = 0; gi < n_req; gi++) begin : g_unpack
      assign addr_arr[gi] = wb_addr[gi*5 +: 5];
      assign data_arr[gi] = wb_data[gi*width +: width];
    end
  endgenerate

  // Search begins just after the last granted requester, wrapping around.
  always_comb begin
    int cand;
    cand        = 0;
    grant_idx   = '0;
    grant_found = 1'b0;
    for (int k = 1; k <= n_req; k++) begin
      cand = (int'(last_reg) + k) % n_req;
      if (!grant_found && wb_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = idx_t'(cand);
      end
    end
  end

  generate
    for (gi = 0; gi < n_req; gi++) begin : g_ready
      assign wb_ready[gi] = reset & grant_found & (grant_idx == idx_t'(gi));
    end
  endgenerate

  assign transfer = |(wb_valid & wb_ready);

  // Register 0 is hardwired; a pending reservation wins over a same-edge commit.
  assign busy_next[0] = 1'b0;
  generate
    for (gi = 1; gi < 32; gi++) begin : g_busy
      assign busy_next[gi] = (rsv_en && (rsv_addr == 5'(gi))) ||
                             (busy_reg[gi] && !(wr_enable_reg && (w_addr_reg == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_reg      <= idx_t'(n_req - 1);
      w_addr_reg    <= '0;
      w_data_reg    <= '0;
      wr_enable_reg <= 1'b0;
      busy_reg      <= '0;
    end else begin
      wr_enable_reg <= transfer && (addr_arr[grant_idx] != 5'd0);
      if (transfer) begin
        last_reg   <= grant_idx;
        w_addr_reg <= addr_arr[grant_idx];
        w_data_reg <= data_arr[grant_idx];
      end
      busy_reg <= busy_next;
    end
  end

  assign W_addr    = w_addr_reg;
  assign W_data    = w_data_reg;
  assign wr_enable = wr_enable_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter: reset, round-robin, $zero writes,
// scoreboard set/clear timing and mid-operation reset.
module tb_regfile_wb_arbiter;

  localparam int width = 32;
  localparam int n_req = 3;

  logic                   clk;
  logic                   reset;
  logic [n_req-1:0]       wb_valid;
  logic [n_req*5-1:0]     wb_addr;
  logic [n_req*width-1:0] wb_data;
  logic [n_req-1:0]       wb_ready;
  logic                   rsv_en;
  logic [4:0]             rsv_addr;
  logic [4:0]             W_addr;
  logic [width-1:0]       W_data;
  logic                   wr_enable;
  logic [31:0]            busy;

  int checks = 0;
  int errors = 0;

  regfile_wb_arbiter #(.width(width), .n_req(n_req)) dut (
    .clk(clk), .reset(reset),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data), .wb_ready(wb_ready),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr),
    .W_addr(W_addr), .W_data(W_data), .wr_enable(wr_enable), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [31:0] d);
    wb_valid[i]             = v;
    wb_addr[i*5 +: 5]       = a;
    wb_data[i*width +: width] = d;
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] rr_addr [6];
  logic [2:0] rr_grant [7];

  initial begin
    rr_addr  = '{5'd5, 5'd6, 5'd7, 5'd5, 5'd6, 5'd7};
    rr_grant = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100, 3'b001};

    // Reset with everything asserted
    reset = 1'b0; rsv_en = 1'b1; rsv_addr = 5'd5;
    wb_valid = '0; wb_addr = '0; wb_data = '0;
    set_req(0, 1'b1, 5'd5, 32'h100);
    set_req(1, 1'b1, 5'd6, 32'h101);
    set_req(2, 1'b1, 5'd7, 32'h102);
    tick(); tick();
    chk("rst_ready", 32'(wb_ready), 32'h0);
    chk("rst_wren", 32'(wr_enable), 32'h0);
    chk("rst_busy", busy, 32'h0);
    chk("rst_waddr", 32'(W_addr), 32'h0);
    $display("step reset: ready=%b wr_enable=%b busy=%h", wb_ready, wr_enable, busy);

    // Round robin, all valid
    reset = 1'b1; rsv_en = 1'b0;
    #1;
    chk("rr_ready0", 32'(wb_ready), 32'(rr_grant[0]));
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("rr_waddr", 32'(W_addr), 32'(rr_addr[n]));
      chk("rr_wdata", W_data, 32'h100 + 32'(n % 3));
      chk("rr_wren", 32'(wr_enable), 32'h1);
      chk("rr_ready", 32'(wb_ready), 32'(rr_grant[n+1]));
      $display("step rr %0d: W_addr=%0d W_data=%h wr_enable=%b next_ready=%b",
               n, W_addr, W_data, wr_enable, wb_ready);
    end
    wb_valid = '0;
    #1;
    chk("idle_ready", 32'(wb_ready), 32'h0);
    tick();
    chk("idle_wren", 32'(wr_enable), 32'h0);
    chk("idle_hold_addr", 32'(W_addr), 32'd7);
    $display("step idle: wr_enable=%b W_addr=%0d", wr_enable, W_addr);

    // Reserve r3, and try reserving r0 which must be ignored
    rsv_en = 1'b1; rsv_addr = 5'd3;
    tick();
    rsv_addr = 5'd0;
    tick();
    rsv_en = 1'b0;
    chk("rsv_busy", busy, 32'h0000_0008);
    $display("step reserve: busy=%h", busy);

    // Zero-register write from requester 1 (pointer currently at 2)
    set_req(1, 1'b1, 5'd0, 32'hDEADBEEF);
    #1;
    chk("zero_ready", 32'(wb_ready), 32'b010);
    tick();
    wb_valid = '0;
    chk("zero_wren", 32'(wr_enable), 32'h0);
    chk("zero_wdata", W_data, 32'hDEADBEEF);
    chk("zero_busy", busy, 32'h0000_0008);
    $display("step zero: wr_enable=%b W_data=%h busy=%h", wr_enable, W_data, busy);

    // Scoreboard: reserve r9 at edge 0, write it at edge 3
    rsv_en = 1'b1; rsv_addr = 5'd9;
    tick();
    rsv_en = 1'b0;
    chk("sb_set", busy, 32'h0000_0208);
    tick();
    tick();
    set_req(2, 1'b1, 5'd9, 32'h1234);
    #1;
    chk("sb_ready", 32'(wb_ready), 32'b100);
    tick();
    wb_valid = '0;
    chk("sb_wren", 32'(wr_enable), 32'h1);
    chk("sb_waddr", 32'(W_addr), 32'd9);
    chk("sb_wdata", W_data, 32'h1234);
    chk("sb_busy_c4", busy, 32'h0000_0208);
    tick();
    chk("sb_busy_c5", busy, 32'h0000_0008);
    chk("sb_wren_c5", 32'(wr_enable), 32'h0);
    $display("step scoreboard: busy=%h wr_enable=%b", busy, wr_enable);

    // Simultaneous set/clear of r12 (pointer at 2, requester 0 next)
    rsv_en = 1'b1; rsv_addr = 5'd12;
    tick();
    rsv_en = 1'b0;
    chk("sc_busy_set", busy, 32'h0000_1008);
    set_req(0, 1'b1, 5'd12, 32'h55);
    #1;
    chk("sc_ready", 32'(wb_ready), 32'b001);
    tick();
    wb_valid = '0;
    chk("sc_wren", 32'(wr_enable), 32'h1);
    rsv_en = 1'b1; rsv_addr = 5'd12;
    tick();
    rsv_en = 1'b0;
    chk("sc_busy_keep", busy, 32'h0000_1008);
    $display("step set_clear: busy=%h", busy);

    // Mid-operation reset (pointer at 0, requester 1 would be granted)
    set_req(0, 1'b1, 5'd5, 32'h200);
    set_req(1, 1'b1, 5'd6, 32'h201);
    set_req(2, 1'b1, 5'd7, 32'h202);
    rsv_en = 1'b1; rsv_addr = 5'd20;
    #1;
    chk("mr_ready_pre", 32'(wb_ready), 32'b010);
    reset = 1'b0;
    #1;
    chk("mr_ready_rst", 32'(wb_ready), 32'h0);
    tick();
    rsv_en = 1'b0;
    chk("mr_wren", 32'(wr_enable), 32'h0);
    chk("mr_busy", busy, 32'h0);
    chk("mr_waddr", 32'(W_addr), 32'h0);
    chk("mr_wdata", W_data, 32'h0);
    reset = 1'b1;
    #1;
    chk("mr_ready_post", 32'(wb_ready), 32'b001);
    tick();
    chk("mr_first_waddr", 32'(W_addr), 32'd5);
    chk("mr_first_wren", 32'(wr_enable), 32'h1);
    $display("step mid_reset: W_addr=%0d wr_enable=%b busy=%h", W_addr, wr_enable, busy);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
